// File: rtl/message_assembler_pkg.sv
// Shared definitions for the message assembler and the byte serializer:
// message capacity, message width, length width and FSM state encoding.
package message_assembler_pkg;

    localparam int MSG_BYTES = 56;
    localparam int MSG_W     = 8 * MSG_BYTES;
    localparam int LEN_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } asm_state_e;

    // MSB position of byte lane idx in a message of width w; byte 0 sits at the top.
    function automatic int lane_msb(input int w, input int idx);
        return w - 1 - 8 * idx;
    endfunction

endpackage

// File: rtl/message_assembler.sv
// Collects a start/stop framed byte stream into a wide, zero-filled message
// and holds it until the consumer acknowledges it.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a start byte; other bytes are dropped
// ST_COLLECT | storing bytes; a full buffer drops bytes and flags overflow
// ST_DONE    | message held stable, msg_valid high, waiting for msg_ack
module message_assembler #(
    parameter int MSG_BYTES = message_assembler_pkg::MSG_BYTES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [7:0]                               byte_in,
    input  logic                                     byte_valid,
    input  logic                                     byte_start,
    input  logic                                     byte_stop,
    output logic                                     byte_ready,
    output logic [8*MSG_BYTES-1:0]                   msg_out,
    output logic [message_assembler_pkg::LEN_W-1:0]  msg_len,
    output logic                                     msg_valid,
    input  logic                                     msg_ack,
    output logic                                     overflow
);
    import message_assembler_pkg::*;

    localparam int MW = 8 * MSG_BYTES;
    localparam logic [LEN_W-1:0] FULL = LEN_W'(MSG_BYTES);

    asm_state_e        state;
    logic [MW-1:0]     buffer;
    logic [LEN_W-1:0]  count;
    logic              accept;

    assign byte_ready = (state != ST_DONE);
    assign accept     = byte_valid & byte_ready;
    assign msg_out    = buffer;
    assign msg_len    = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            buffer    <= '0;
            count     <= '0;
            msg_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept && byte_start) begin
            // A start byte opens a fresh message from IDLE or COLLECT alike.
            buffer                   <= '0;
            buffer[MW-1 -: 8]        <= byte_in;
            count                    <= LEN_W'(1);
            overflow                 <= 1'b0;
            state                    <= byte_stop ? ST_DONE : ST_COLLECT;
            msg_valid                <= byte_stop;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_COLLECT: begin
                    if (accept) begin
                        if (count == FULL) begin
                            overflow <= 1'b1;
                        end else begin
                            for (int i = 0; i < MSG_BYTES; i++) begin
                                if (count == LEN_W'(i))
                                    buffer[lane_msb(MW, i) -: 8] <= byte_in;
                            end
                            count <= count + 1'b1;
                        end
                        if (byte_stop) begin
                            state     <= ST_DONE;
                            msg_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (msg_ack) begin
                        state     <= ST_IDLE;
                        msg_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    msg_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_message_assembler.sv
// Self-checking bench for message_assembler: a vector table for single-cycle
// behaviour, a message scoreboard, and hand sequences for the long corner cases.
module tb_message_assembler;
    import message_assembler_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_start;
    logic         byte_stop;
    logic         byte_ready;
    logic [447:0] msg_out;
    logic [5:0]   msg_len;
    logic         msg_valid;
    logic         msg_ack;
    logic         overflow;

    message_assembler #(.MSG_BYTES(56)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_start (byte_start),
        .byte_stop  (byte_stop),
        .byte_ready (byte_ready),
        .msg_out    (msg_out),
        .msg_len    (msg_len),
        .msg_valid  (msg_valid),
        .msg_ack    (msg_ack),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [447:0] act, input logic [447:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bytes of the open message kept in a queue.
    typedef struct {
        logic [447:0] msg;
        logic [5:0]   len;
        logic         ovf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_bytes[$];
    bit         m_active = 0;
    bit         m_done = 0;
    bit         m_ovf = 0;

    function automatic logic [447:0] pack_msg();
        logic [447:0] r = '0;
        foreach (m_bytes[i]) r[447-8*i -: 8] = m_bytes[i];
        return r;
    endfunction

    function automatic void model_reset();
        m_bytes.delete();
        m_active = 0;
        m_done = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_update(input logic v, input logic [7:0] d,
                                         input logic s, input logic p, input logic a);
        exp_t e;
        if (m_done) begin
            if (a) m_done = 0;
        end else if (v) begin
            if (s) begin
                m_bytes.delete();
                m_bytes.push_back(d);
                m_ovf = 0;
                m_active = 1;
            end else if (m_active) begin
                if (m_bytes.size() < 56) m_bytes.push_back(d);
                else m_ovf = 1;
            end
            if (m_active && p) begin
                m_active = 0;
                m_done = 1;
                e.msg = pack_msg();
                e.len = 6'(m_bytes.size());
                e.ovf = m_ovf;
                sb.push_back(e);
            end
        end
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic s,
                        input logic p, input logic a);
        byte_valid = v;
        byte_in    = d;
        byte_start = s;
        byte_stop  = p;
        msg_ack    = a;
        model_update(v, d, s, p, a);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: each new message is popped when msg_valid rises.
    bit prev_v = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && msg_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_msg", 448'(1), 448'(0));
            end else begin
                e = sb.pop_front();
                check("sb_msg_out", msg_out, e.msg);
                check("sb_msg_len", 448'(msg_len), 448'(e.len));
                check("sb_overflow", 448'(overflow), 448'(e.ovf));
            end
        end
        prev_v = rst_n && msg_valid;
    end

    typedef struct {
        logic         v;
        logic [7:0]   d;
        logic         s;
        logic         p;
        logic         a;
        logic         e_ready;
        logic         e_valid;
        logic [5:0]   e_len;
        logic         e_ovf;
        logic         chk;
        logic [447:0] e_msg;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v  d      s  p  a  rdy vld len ovf chk msg
        tbl[0]  = '{1, 8'h41, 1, 0, 0, 1, 0, 6'd1, 0, 0, 448'd0};
        tbl[1]  = '{1, 8'h42, 0, 0, 0, 1, 0, 6'd2, 0, 0, 448'd0};
        tbl[2]  = '{1, 8'h43, 0, 1, 0, 0, 1, 6'd3, 0, 1, {24'h414243, 424'd0}};
        tbl[3]  = '{1, 8'h99, 0, 0, 0, 0, 1, 6'd3, 0, 1, {24'h414243, 424'd0}};
        tbl[4]  = '{0, 8'h00, 0, 0, 1, 1, 0, 6'd3, 0, 0, 448'd0};
        tbl[5]  = '{1, 8'hAA, 0, 0, 0, 1, 0, 6'd3, 0, 1, {24'h414243, 424'd0}};
        tbl[6]  = '{1, 8'hAA, 1, 0, 0, 1, 0, 6'd1, 0, 0, 448'd0};
        tbl[7]  = '{1, 8'hBB, 0, 0, 0, 1, 0, 6'd2, 0, 0, 448'd0};
        tbl[8]  = '{1, 8'hCC, 1, 0, 0, 1, 0, 6'd1, 0, 1, {8'hCC, 440'd0}};
        tbl[9]  = '{1, 8'hDD, 0, 1, 0, 0, 1, 6'd2, 0, 1, {16'hCCDD, 432'd0}};
        tbl[10] = '{0, 8'h00, 0, 0, 1, 1, 0, 6'd2, 0, 0, 448'd0};
        tbl[11] = '{1, 8'h00, 1, 0, 0, 1, 0, 6'd1, 0, 0, 448'd0};
        tbl[12] = '{1, 8'h00, 0, 0, 0, 1, 0, 6'd2, 0, 0, 448'd0};
        tbl[13] = '{1, 8'h07, 0, 1, 0, 0, 1, 6'd3, 0, 1, {24'h000007, 424'd0}};
        tbl[14] = '{0, 8'h00, 0, 0, 1, 1, 0, 6'd3, 0, 0, 448'd0};
        tbl[15] = '{1, 8'h11, 0, 1, 1, 1, 0, 6'd3, 0, 1, {24'h000007, 424'd0}};

        rst_n = 1'b0;
        byte_in = 8'h00; byte_valid = 0; byte_start = 0; byte_stop = 0; msg_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_msg_out", msg_out, 448'd0);
        check("rst_msg_len", 448'(msg_len), 448'd0);
        check("rst_msg_valid", 448'(msg_valid), 448'd0);
        check("rst_overflow", 448'(overflow), 448'd0);
        check("rst_byte_ready", 448'(byte_ready), 448'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].p, tbl[i].a);
            check($sformatf("row%0d_ready", i), 448'(byte_ready), 448'(tbl[i].e_ready));
            check($sformatf("row%0d_valid", i), 448'(msg_valid), 448'(tbl[i].e_valid));
            check($sformatf("row%0d_len", i), 448'(msg_len), 448'(tbl[i].e_len));
            check($sformatf("row%0d_ovf", i), 448'(overflow), 448'(tbl[i].e_ovf));
            if (tbl[i].chk) check($sformatf("row%0d_msg", i), msg_out, tbl[i].e_msg);
        end

        // Exactly full message.
        for (int i = 1; i <= 56; i++)
            step(1, 8'(i), i == 1, i == 56, 0);
        check("full_valid", 448'(msg_valid), 448'd1);
        check("full_len", 448'(msg_len), 448'd56);
        check("full_last_byte", 448'(msg_out[7:0]), 448'h38);
        check("full_first_byte", 448'(msg_out[447:440]), 448'h01);
        check("full_ovf", 448'(overflow), 448'd0);
        step(0, 8'h00, 0, 0, 1);

        // Two bytes beyond capacity are dropped and flag overflow.
        for (int i = 1; i <= 58; i++)
            step(1, 8'(i + 8'h80), i == 1, i == 58, 0);
        check("ovf_len", 448'(msg_len), 448'd56);
        check("ovf_flag", 448'(overflow), 448'd1);
        check("ovf_last_byte", 448'(msg_out[7:0]), 448'hB8);
        step(0, 8'h00, 0, 0, 1);
        check("ovf_sticky_idle", 448'(overflow), 448'd1);
        step(1, 8'h21, 1, 0, 0);
        check("ovf_cleared_by_start", 448'(overflow), 448'd0);

        // Single-byte message held through 5 cycles without ack.
        step(1, 8'h55, 1, 1, 0);
        check("hold_valid_latency", 448'(msg_valid), 448'd1);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'(8'h60 + i), i == 2, i == 4, 0);
            check($sformatf("hold%0d_ready", i), 448'(byte_ready), 448'd0);
            check($sformatf("hold%0d_msg", i), msg_out, {8'h55, 440'd0});
            check($sformatf("hold%0d_len", i), 448'(msg_len), 448'd1);
        end
        step(0, 8'h00, 0, 0, 1);
        check("ack_valid_low", 448'(msg_valid), 448'd0);
        check("ack_ready_high", 448'(byte_ready), 448'd1);

        // Reset in the middle of a message.
        for (int i = 0; i < 10; i++)
            step(1, 8'(8'hC0 + i), i == 0, 0, 0);
        check("mid_len_before_rst", 448'(msg_len), 448'd10);
        rst_n = 1'b0;
        byte_valid = 0; byte_start = 0; byte_stop = 0; msg_ack = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_len", 448'(msg_len), 448'd0);
        check("midrst_msg", msg_out, 448'd0);
        check("midrst_state", 448'(dut.state), 448'(ST_IDLE));
        check("midrst_valid", 448'(msg_valid), 448'd0);
        step(1, 8'h77, 0, 0, 0);
        check("midrst_drop_len", 448'(msg_len), 448'd0);
        check("midrst_drop_msg", msg_out, 448'd0);
        step(1, 8'h78, 1, 1, 0);
        check("midrst_restart_len", 448'(msg_len), 448'd1);
        step(0, 8'h00, 0, 0, 1);

        check("sb_drained", 448'(sb.size()), 448'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
